store_rmw_ctrl: RTL
===================

Name: store_rmw_ctrl

Overview:
Sequences sub-word stores (sb/sh) as read-modify-write transactions on the 32-bit data memory. Full-word stores go straight to memory. For byte and halfword stores, the block reads the aligned word, merges the new bytes using the team's lane rules, and writes the word back. It sits between the core's memory-stage store request and the data memory port.

Parameters:
READ_LAT, 1, cycles from the mem_rd cycle to valid mem_rdata; legal range 1..4.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  store request present
req_ready  output  1  block can accept a request
req_addr  input  32  byte address
req_data  input  32  store value; byte uses [7:0], half uses [15:0]
req_size  input  2  00 word, 01 half, 10 byte, 11 illegal
mem_addr  output  32  word-aligned memory address
mem_rd  output  1  memory read strobe
mem_rdata  input  32  memory read data
mem_wr  output  1  memory write strobe
mem_wdata  output  32  memory write data
done  output  1  one-cycle pulse when the write is issued
err  output  1  one-cycle pulse when a request is rejected
busy  output  1  high in every state except IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state IDLE, all outputs 0 except req_ready=1. Internal address, data, size, read-word and counter registers are all 0.
- Handshake: req_ready=1 only in IDLE. A request is accepted on the clk edge where req_valid && req_ready. At that edge, req_addr, req_data and req_size are latched; later changes on req_* are ignored.
- State IDLE, on accept:
  - size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> ERR.
  - word -> WRITE.
  - otherwise -> READ.
- State READ (1 cycle): mem_rd=1, mem_addr={addr[31:2],2'b00}. Next state WAIT; counter loaded with READ_LAT.
- State WAIT (READ_LAT cycles): mem_rd=0, mem_addr held. The counter decrements each cycle. In the cycle where the counter equals 1, mem_rdata is captured at the clk edge and the state moves to WRITE.
- State WRITE (1 cycle): mem_wr=1, mem_addr aligned, done=1, mem_wdata as below. Next state IDLE.
- mem_wdata merge rules (R = captured word, D = latched data):
  - word: D.
  - half, addr[1]=0: {R[31:16],D[15:0]}.
  - half, addr[1]=1: {D[15:0],R[15:0]}.
  - byte, addr[1:0]=00: {R[31:8],D[7:0]}.
  - byte, addr[1:0]=01: {R[31:16],D[7:0],R[7:0]}.
  - byte, addr[1:0]=10: {R[31:24],D[7:0],R[15:0]}.
  - byte, addr[1:0]=11: {D[7:0],R[23:0]}.
- State ERR (1 cycle): err=1, no memory strobes. Next state IDLE.
- Outside READ/WAIT/WRITE: mem_addr=0 and mem_wdata=0. mem_rd and mem_wr are never high in the same cycle.
- Latency from accept edge at end of cycle T:
  - word: write in T+1.
  - sub-word: read in T+1, write in T+2+READ_LAT.
  - error: err in T+1.
- Throughput: after WRITE or ERR the block returns to IDLE. A new request can be accepted in that IDLE cycle, i.e. one bubble between transactions.
- Reset mid-operation: the block returns to IDLE immediately. A pending write is never issued, and no done or err pulse is emitted for the aborted request.

Test Plan:
1. Word store: addr 0x100, data 0xDEADBEEF, size 00 -> single cycle T+1 with mem_wr=1, mem_addr 0x100, mem_wdata 0xDEADBEEF, done=1; mem_rd never asserted.
2. Byte store, READ_LAT=1: addr 0x203, data 0x000000AB, memory word at 0x200 = 0x11223344 -> mem_rd in T+1 at 0x200; in T+3 mem_wr=1 with mem_wdata 0xAB223344 and done=1.
3. Halfword store, READ_LAT=3: addr 0x302, data 0x0000CAFE, memory word 0x55667788 -> mem_wr at T+5 with mem_wdata 0xCAFE7788; busy=1 from T+1 through T+5.
4. Illegal requests: half at 0x401, word at 0x402, size 11 -> err pulses in T+1 for each; no mem_rd/mem_wr; req_ready=1 again in T+2.
5. Back-to-back requests, req_valid held high: byte 0x500 then word 0x504 -> second request accepted in the IDLE cycle right after the first WRITE; both writes correct; the first write's mem_wdata low byte equals the first request's data[7:0].
6. Reset in WAIT: drop reset_n during WAIT of a byte store -> outputs return to their reset values asynchronously; no mem_wr and no done follow; after release req_ready=1.

Source files
------------

// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: turns core store requests into memory writes. Full-word
// stores are written directly; byte and halfword stores read the aligned
// word, merge the new bytes into the proper lanes and write the word back.
module store_rmw_ctrl #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;

  localparam logic [2:0] LAT     = 3'(READ_LAT);
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rword_q, rword_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        reqIllegal;
  logic [31:0] alignedAddr;
  logic [31:0] mergedData;

  // Misaligned or undefined-size requests are rejected instead of written.
  assign reqIllegal = (req_size == SZ_ILL) ||
                      ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  assign alignedAddr = {addr_q[31:2], 2'b00};

  // Lane merge: drop the latched store bytes into the captured memory word.
  always_comb begin
    mergedData = data_q;
    case (size_q)
      SZ_HALF: begin
        if (addr_q[1]) mergedData = {data_q[15:0], rword_q[15:0]};
        else           mergedData = {rword_q[31:16], data_q[15:0]};
      end
      SZ_BYTE: begin
        case (addr_q[1:0])
          2'b00:   mergedData = {rword_q[31:8], data_q[7:0]};
          2'b01:   mergedData = {rword_q[31:16], data_q[7:0], rword_q[7:0]};
          2'b10:   mergedData = {rword_q[31:24], data_q[7:0], rword_q[15:0]};
          default: mergedData = {data_q[7:0], rword_q[23:0]};
        endcase
      end
      default: mergedData = data_q;
    endcase
  end

  // Next-state and output decode; outputs idle low unless a state drives them.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    size_d    = size_q;
    rword_d   = rword_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    mem_addr  = 32'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 32'd0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d = req_addr;
          data_d = req_data;
          size_d = req_size;
          if (reqIllegal)              state_d = ERR;
          else if (req_size == SZ_WORD) state_d = WRITE;
          else                          state_d = READ;
        end
      end
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = alignedAddr;
        cnt_d    = LAT;
        state_d  = WAIT;
      end
      WAIT: begin
        mem_addr = alignedAddr;
        cnt_d    = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rword_d = mem_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = alignedAddr;
        mem_wdata = mergedData;
        done      = 1'b1;
        state_d   = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      size_q  <= 2'b00;
      rword_q <= 32'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      rword_q <= rword_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
